// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the sequencer (master) and the single-bus datapath/memory (slave).
// Memory handshake: mem_req is held, with every other output stable, until mem_ready
// is high; the access completes on the first rising edge where both are high.
interface cpu_control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [23:0] bus_out_sel;
  logic [15:0] reg_in_en;
  logic        y_in;
  logic        z_in;
  logic        hi_in;
  logic        lo_in;
  logic        pc_in;
  logic        ir_in;
  logic        mar_in;
  logic        mdr_in;
  logic        mdr_read;
  logic        mem_req;
  logic        mem_we;
  logic [4:0]  alu_op;
  logic        halted;
  logic        fault;

  modport master (
    input  run, ir, mem_ready,
    output bus_out_sel, reg_in_en, y_in, z_in, hi_in, lo_in, pc_in, ir_in,
           mar_in, mdr_in, mdr_read, mem_req, mem_we, alu_op, halted, fault
  );

  modport slave (
    output run, ir, mem_ready,
    input  bus_out_sel, reg_in_en, y_in, z_in, hi_in, lo_in, pc_in, ir_in,
           mar_in, mdr_in, mdr_read, mem_req, mem_we, alu_op, halted, fault
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the single-bus 32-bit datapath.
// Moore outputs decoded from the state register and the IR opcode/register fields.
module cpu_control_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    clear,
  cpu_control_sequencer_if.master bus,
  output logic [3:0]              state_dbg
);
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_INC = 5'b11111;

  localparam int B_HI = 16, B_LO = 17, B_ZH = 18, B_ZL = 19;
  localparam int B_PC = 20, B_MDR = 21, B_C = 23;

  // Address width lives in the datapath; kept here so width changes stay local.
  localparam int unused_addr_w = ADDR_W;

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_rtype, is_imm, is_mem_state;
  logic       unused_ir_low;

  assign op = bus.ir[31:27];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];
  // Low IR bits hold the immediate, consumed by the datapath rather than here.
  assign unused_ir_low = ^bus.ir[14:0];

  assign is_rtype     = (op >= 5'b00011) && (op <= 5'b01000);
  assign is_imm       = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
  assign is_mem_state = (state == S_T1) ||
                        ((state == S_T6) && (op == OP_LD)) ||
                        ((state == S_T7) && (op == OP_ST));
  assign state_dbg    = state;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    state_t done_nx;
    done_nx     = bus.run ? S_T0 : S_IDLE;
    state_nx    = state;
    wait_cnt_nx = '0;
    case (state)
      S_IDLE: if (bus.run) state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      S_T2:   state_nx = S_T3;
      S_T3: begin
        if (is_rtype || is_imm || (op == OP_MUL)) state_nx = S_T4;
        else if (op == OP_NOP)                    state_nx = done_nx;
        else if (op == OP_HALT)                   state_nx = S_HALT;
        else                                      state_nx = S_FAULT;
      end
      S_T4:   state_nx = S_T5;
      S_T5:   state_nx = ((op == OP_LD) || (op == OP_ST) || (op == OP_MUL)) ? S_T6 : done_nx;
      S_T6:   state_nx = (op == OP_MUL) ? done_nx : S_T7;
      S_T7:   state_nx = done_nx;
      default: state_nx = state;
    endcase
    // A stalled memory state holds until mem_ready, or faults once the budget is spent.
    if (is_mem_state && !bus.mem_ready) begin
      if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
        state_nx = S_FAULT;
      end else begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    bus.bus_out_sel = '0;
    bus.reg_in_en   = '0;
    bus.y_in        = 1'b0;
    bus.z_in        = 1'b0;
    bus.hi_in       = 1'b0;
    bus.lo_in       = 1'b0;
    bus.pc_in       = 1'b0;
    bus.ir_in       = 1'b0;
    bus.mar_in      = 1'b0;
    bus.mdr_in      = 1'b0;
    bus.mdr_read    = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.alu_op      = '0;
    bus.halted      = 1'b0;
    bus.fault       = 1'b0;
    case (state)
      S_T0: begin
        bus.bus_out_sel = 24'd1 << B_PC;
        bus.mar_in      = 1'b1;
        bus.z_in        = 1'b1;
        bus.alu_op      = ALU_INC;
      end
      S_T1: begin
        bus.bus_out_sel = 24'd1 << B_ZL;
        bus.pc_in       = 1'b1;
        bus.mdr_in      = 1'b1;
        bus.mdr_read    = 1'b1;
        bus.mem_req     = 1'b1;
      end
      S_T2: begin
        bus.bus_out_sel = 24'd1 << B_MDR;
        bus.ir_in       = 1'b1;
      end
      S_T3: begin
        if (is_rtype || is_imm) begin
          bus.bus_out_sel = 24'd1 << rb;
          bus.y_in        = 1'b1;
        end else if (op == OP_MUL) begin
          bus.bus_out_sel = 24'd1 << ra;
          bus.y_in        = 1'b1;
        end
      end
      S_T4: begin
        bus.z_in = is_rtype || is_imm || (op == OP_MUL);
        if (is_rtype) begin
          bus.bus_out_sel = 24'd1 << rc;
          bus.alu_op      = op;
        end else if (is_imm) begin
          bus.bus_out_sel = 24'd1 << B_C;
          bus.alu_op      = ALU_ADD;
        end else if (op == OP_MUL) begin
          bus.bus_out_sel = 24'd1 << rb;
          bus.alu_op      = OP_MUL;
        end
      end
      S_T5: begin
        bus.bus_out_sel = 24'd1 << B_ZL;
        if ((op == OP_LD) || (op == OP_ST)) bus.mar_in    = 1'b1;
        else if (op == OP_MUL)              bus.lo_in     = 1'b1;
        else                                bus.reg_in_en = 16'd1 << ra;
      end
      S_T6: begin
        if (op == OP_LD) begin
          bus.mdr_in   = 1'b1;
          bus.mdr_read = 1'b1;
          bus.mem_req  = 1'b1;
        end else if (op == OP_ST) begin
          bus.bus_out_sel = 24'd1 << ra;
          bus.mdr_in      = 1'b1;
        end else begin
          bus.bus_out_sel = 24'd1 << B_ZH;
          bus.hi_in       = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          bus.bus_out_sel = 24'd1 << B_MDR;
          bus.reg_in_en   = 16'd1 << ra;
        end else begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
        end
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: a micro-program reference model built from the
// instruction step tables feeds an expected queue checked cycle by cycle.
module tb_cpu_control_sequencer;
  typedef struct packed {
    logic [23:0] srcs;
    logic [15:0] regs;
    logic y, z, hi, lo, pc, irl, mar, mdr, rd, req, we;
    logic [4:0]  alu;
    logic halted, fault;
  } ctl_t;
  localparam int W = $bits(ctl_t);

  localparam logic [10:0] F_Y = 11'h400, F_Z = 11'h200, F_HI = 11'h100, F_LO = 11'h080;
  localparam logic [10:0] F_PC = 11'h040, F_IR = 11'h020, F_MAR = 11'h010, F_MDR = 11'h008;
  localparam logic [10:0] F_RD = 11'h004, F_REQ = 11'h002, F_WE = 11'h001;
  localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21, S_C = 23;

  logic       clock;
  logic       clear;
  logic [3:0] state_dbg;
  logic [W-1:0] exp_q[$];
  int n_pass;
  int n_checks;
  bit in_idle;
  logic [4:0] legal_ops [11] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12, 5'd0, 5'd2, 5'd15, 5'd24};

  cpu_control_sequencer_if bus();

  cpu_control_sequencer #(.ADDR_W(32), .MEM_TIMEOUT(255)) dut (
    .clock     (clock),
    .clear     (clear),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic ctl_t uop(input int src, input int gin, input logic [10:0] f, input logic [4:0] alu);
    ctl_t c;
    c = '0;
    if (src >= 0) c.srcs[src] = 1'b1;
    if (gin >= 0) c.regs[gin] = 1'b1;
    {c.y, c.z, c.hi, c.lo, c.pc, c.irl, c.mar, c.mdr, c.rd, c.req, c.we} = f;
    c.alu = alu;
    return c;
  endfunction

  function automatic void model_instr(input logic [31:0] irv);
    logic [4:0] op;
    int ra, rb, rc;
    ctl_t t;
    op = irv[31:27];
    ra = int'(irv[26:23]);
    rb = int'(irv[22:19]);
    rc = int'(irv[18:15]);
    exp_q.push_back(uop(S_PC, -1, F_MAR | F_Z, 5'b11111));
    exp_q.push_back(uop(S_ZL, -1, F_PC | F_MDR | F_RD | F_REQ, 5'b0));
    exp_q.push_back(uop(S_MDR, -1, F_IR, 5'b0));
    if ((op >= 5'd3 && op <= 5'd8) || op == 5'd12 || op == 5'd0 || op == 5'd2) begin
      exp_q.push_back(uop(rb, -1, F_Y, 5'b0));
      if (op >= 5'd3 && op <= 5'd8) exp_q.push_back(uop(rc, -1, F_Z, op));
      else                          exp_q.push_back(uop(S_C, -1, F_Z, 5'b00011));
      if (op == 5'd0 || op == 5'd2) exp_q.push_back(uop(S_ZL, -1, F_MAR, 5'b0));
      else                          exp_q.push_back(uop(S_ZL, ra, 11'h0, 5'b0));
      if (op == 5'd0) begin
        exp_q.push_back(uop(-1, -1, F_MDR | F_RD | F_REQ, 5'b0));
        exp_q.push_back(uop(S_MDR, ra, 11'h0, 5'b0));
      end else if (op == 5'd2) begin
        exp_q.push_back(uop(ra, -1, F_MDR, 5'b0));
        exp_q.push_back(uop(-1, -1, F_REQ | F_WE, 5'b0));
      end
    end else if (op == 5'd15) begin
      exp_q.push_back(uop(ra, -1, F_Y, 5'b0));
      exp_q.push_back(uop(rb, -1, F_Z, 5'b01111));
      exp_q.push_back(uop(S_ZL, -1, F_LO, 5'b0));
      exp_q.push_back(uop(S_ZH, -1, F_HI, 5'b0));
    end else begin
      exp_q.push_back('0);
      t = '0;
      if (op == 5'd25) t.halted = 1'b1;
      else if (op != 5'd24) t.fault = 1'b1;
      if (op != 5'd24) exp_q.push_back(t);
    end
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.srcs = bus.bus_out_sel; c.regs = bus.reg_in_en;
    c.y = bus.y_in; c.z = bus.z_in; c.hi = bus.hi_in; c.lo = bus.lo_in;
    c.pc = bus.pc_in; c.irl = bus.ir_in; c.mar = bus.mar_in; c.mdr = bus.mdr_in;
    c.rd = bus.mdr_read; c.req = bus.mem_req; c.we = bus.mem_we;
    c.alu = bus.alu_op; c.halted = bus.halted; c.fault = bus.fault;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input ctl_t obs, input ctl_t expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic do_reset(input string tag);
    clear = 1'b0;
    #1;
    check({tag, "_async"}, observe(), '0);
    tick();
    check({tag, "_held"}, observe(), '0);
    clear = 1'b1;
    bus.run = 1'b0;
    exp_q.delete();
    in_idle = 1'b1;
    tick();
    check({tag, "_idle"}, observe(), '0);
  endtask

  task automatic start(input logic [31:0] irv, input bit keep);
    bus.ir = irv;
    if (in_idle) begin
      check("idle_before_start", observe(), '0);
      bus.run = 1'b1;
      tick();
    end
    bus.run = keep;
    in_idle = !keep;
    model_instr(irv);
  endtask

  task automatic play(input int nsteps, input int stall, input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && (nsteps < 0 || k < nsteps)) begin
      ctl_t e;
      int n;
      e = exp_q.pop_front();
      if (e.req) begin
        n = (stall < 0) ? int'($urandom_range(0, 4)) : stall;
        for (int s = 0; s <= n; s++) begin
          bus.mem_ready = (s == n);
          check($sformatf("%s step%0d wait%0d", tag, k, s), observe(), e);
          tick();
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        check($sformatf("%s step%0d", tag, k), observe(), e);
        tick();
      end
      k++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    ctl_t e;
    ctl_t fv;
    logic [31:0] r;
    logic [31:0] irv;
    bit keep;
    n_pass = 0;
    n_checks = 0;
    clear = 1'b0;
    bus.run = 1'b0;
    bus.ir = '0;
    bus.mem_ready = 1'b0;
    in_idle = 1'b1;
    #2;
    check("reset_outputs", observe(), '0);
    #10;
    clear = 1'b1;
    repeat (2) begin
      tick();
      check("idle_run_low", observe(), '0);
    end

    // fetch of add R0,R0,R0 with memory always ready, then add R3,R5,R7
    start(32'h1800_0000, 1'b1);
    play(-1, 0, "add_r0");
    start(32'h19AB_8000, 1'b1);
    play(-1, 0, "add_r3_r5_r7");

    // ld R2,C(R4) with three stall cycles on each memory step, then park
    start({5'b00000, 4'd2, 4'd4, 19'h1234}, 1'b0);
    play(-1, 3, "ld_stall3");
    check("ld_parked", observe(), '0);

    // randomized legal instruction stream
    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      irv = {legal_ops[$urandom_range(0, 10)], r[26:0]};
      keep = 1'($urandom_range(0, 1));
      start(irv, keep);
      play(-1, -1, $sformatf("rnd%0d_op%0d", i, irv[31:27]));
    end

    // st with memory never ready at the write step
    do_reset("rst_pre_st");
    start({5'b00010, 4'd6, 4'd9, 19'h0}, 1'b1);
    play(7, 0, "st_pre");
    e = exp_q.pop_front();
    for (int k = 0; k < 255; k++) begin
      bus.mem_ready = 1'b0;
      check($sformatf("st_stall%0d", k), observe(), e);
      tick();
    end
    fv = '0;
    fv.fault = 1'b1;
    check("st_timeout_fault", observe(), fv);
    tick();
    check("st_fault_sticky", observe(), fv);
    do_reset("rst_after_timeout");

    // halt: terminal until clear regardless of run
    start({5'b11001, 27'h0}, 1'b1);
    play(-1, -1, "halt");
    e = '0;
    e.halted = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.run = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      check($sformatf("halt_hold%0d", k), observe(), e);
      tick();
    end
    do_reset("rst_after_halt");

    // illegal opcode
    start({5'b10101, 27'h0}, 1'b1);
    play(-1, -1, "illegal");
    check("illegal_fault_sticky", observe(), fv);
    do_reset("rst_after_illegal");

    // clear asserted mid-T4 of mul
    start({5'b01111, 4'd1, 4'd2, 19'h0}, 1'b0);
    play(4, 0, "mul_pre");
    e = exp_q.pop_front();
    check("mul_t4", observe(), e);
    #3;
    clear = 1'b0;
    #1;
    check("mul_clear_async", observe(), '0);
    exp_q.delete();
    tick();
    check("mul_clear_held", observe(), '0);
    clear = 1'b1;
    bus.run = 1'b0;
    in_idle = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("mul_after_clear%0d", k), observe(), '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Multi-cycle control unit for the single-bus 32-bit datapath.
- Sequences fetch, decode and execute for a fixed instruction subset.
- Drives the one-hot bus-source vector into the bus encoder, register load enables, ALU opcode and memory handshake.
- Decodes from the datapath IR output.

Parameters:
- ADDR_W, 32, unused width marker for PC/MAR; kept so future address width changes stay local.
- MEM_TIMEOUT, 255, max wait cycles on mem_ready before fault (8-bit counter).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset; asynchronous, active-low.
- run  in  1  start/continue fetching when high.
- ir  in  32  IR register output; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- mem_ready  in  1  memory completes the current access this cycle.
- bus_out_sel  out  24  one-hot bus source. Bits 0-15 R0-R15out, 16 HIout, 17 LOout, 18 ZHighout, 19 ZLowout, 20 PCout, 21 MDRout, 22 InPortout, 23 Cout.
- reg_in_en  out  16  GPR load enables R0-R15.
- y_in, z_in, hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in  out  1 each  register load enables.
- mdr_read  out  1  MDR loads from memory (1) or bus (0).
- mem_req  out  1  memory access request.
- mem_we  out  1  write when mem_req=1.
- alu_op  out  5  ALU operation.
- halted  out  1  HALT state reached.
- fault  out  1  sticky: illegal opcode or memory timeout.

Behaviour:
- States: IDLE, T0-T7, HALT, FAULT. State register is reset asynchronously when clear=0.
- Reset values:
  - State = IDLE; wait counter = 0.
  - All outputs are 0. alu_op = 00000.
- Outputs are Moore: decoded from the state register and ir only.
- Outside the listed steps, every output is 0.
- bus_out_sel has at most one bit set in every cycle.
- IDLE: go to T0 when run=1.
- Fetch:
  - T0: PCout, mar_in, z_in, alu_op=11111 (PC+1).
  - T1: ZLowout, pc_in, mdr_in, mdr_read, mem_req.
  - T2: MDRout, ir_in.
- Execute sequences, keyed by opcode (ir[31:27]); the step after the last step of each goes to T0 if run=1, else IDLE:
  - R-type ALU (00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl):
    - T3: Rb out, y_in.
    - T4: Rc out, z_in, alu_op = opcode.
    - T5: ZLowout, Ra in.
  - addi (01100):
    - T3: Rb out, y_in.
    - T4: Cout, z_in, alu_op=00011.
    - T5: ZLowout, Ra in.
  - ld (00000):
    - T3 and T4 as for addi.
    - T5: ZLowout, mar_in.
    - T6: mdr_in, mdr_read, mem_req.
    - T7: MDRout, Ra in.
  - st (00010):
    - T3-T5 as for ld.
    - T6: Ra out, mdr_in (mdr_read=0).
    - T7: mem_req, mem_we.
  - mul (01111):
    - T3: Ra out, y_in.
    - T4: Rb out, z_in, alu_op=01111.
    - T5: ZLowout, lo_in.
    - T6: ZHighout, hi_in.
  - nop (11000): T3 goes straight to T0/IDLE; no outputs.
  - halt (11001): T3 goes to HALT; halted=1. HALT is left only via clear.
  - Any other opcode: T3 goes to FAULT.
- Memory wait:
  - Memory states are T1, ld T6 and st T7.
  - In these states the state is held, with outputs stable, while mem_ready=0.
  - The state advances on the first edge with mem_ready=1.
  - The wait counter increments each stall cycle and clears when the state advances.
  - Counter reaching MEM_TIMEOUT with mem_ready=0 goes to FAULT.
- FAULT: fault=1, all other outputs 0. Left only via clear.
- Reset mid-instruction (clear low in any state): immediate return to IDLE, outputs 0, fault/halted cleared. No partial write is issued after clear.
- run dropping mid-instruction: the instruction completes; the sequencer then parks in IDLE.
- Ra/Rb/Rc map directly to a 4-bit index: one-hot bit n of bus_out_sel or reg_in_en. R0 has no special case.

Test Plan:
- Fetch, mem_ready tied 1, ir=0x18000000 (add R0,R0,R0 opcode 00011):
  - T0: bus_out_sel=0x100000, mar_in, z_in, alu_op=11111.
  - T1: bit19 set, pc_in, mem_req.
  - T2: bit21 set, ir_in.
  - Returns to T0 after T5.
- add R3,R5,R7 (ir=0x19AB8000):
  - T3: bus_out_sel=0x000020 with y_in.
  - T4: 0x000080, alu_op=00011.
  - T5: 0x080000 with reg_in_en=0x0008.
- ld R2,C(R4) with mem_ready low 3 cycles at T6: T6 is held exactly 4 cycles with mem_req=1, then T7 drives MDRout and reg_in_en=0x0004.
- st then mem_ready stuck 0: fault=1 after 255 stall cycles, all other outputs 0. Pulse clear low: state IDLE, fault=0.
- Opcode 11001 (halt): halted=1 from the cycle after T3 and stays high for 20 cycles regardless of run. Opcode 10101: fault=1.
- clear asserted asynchronously mid-T4 of mul: outputs 0 before the next clock edge; no hi_in/lo_in pulses follow.
